// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - request/result handshake bundle for alu_mc
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] accum;
    logic [WIDTH-1:0] data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             carry;
    logic             neg;

    modport slave (
        input  in_valid, opcode, accum, data, out_ready,
        output in_ready, out_valid, out, zero, carry, neg
    );

    modport master (
        output in_valid, opcode, accum, data, out_ready,
        input  in_ready, out_valid, out, zero, carry, neg
    );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - handshaked ALU with single-cycle ops and a shift-add multiply
module alu_mc #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input logic     clk,
    input logic     rst_,
    alu_mc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t             state, state_nx;
    logic               accept;
    logic               is_mul;
    logic               mul_last;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   out_r;
    logic               carry_r;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nx;
    logic [CW-1:0]      cnt;

    assign is_mul   = (bus.opcode == 3'd7) && (MUL_EN != 0);
    assign accept   = bus.in_valid && bus.in_ready;
    assign mul_last = (state == BUSY) && (cnt == CW'(WIDTH - 1));
    assign prod_nx  = prod + (mplier[0] ? mcand : '0);

    assign sum  = {1'b0, bus.accum} + {1'b0, bus.data};
    // Top bit of the extended difference is the unsigned borrow.
    assign diff = {1'b0, bus.accum} - {1'b0, bus.data};

    always_comb begin
        bus.in_ready = 1'b0;
        if (rst_) begin
            case (state)
                IDLE:    bus.in_ready = 1'b1;
                DONE:    bus.in_ready = bus.out_ready;
                default: bus.in_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        res   = bus.accum;
        res_c = 1'b0;
        case (bus.opcode)
            3'd1:    {res_c, res} = sum;
            3'd2:    {res_c, res} = diff;
            3'd3:    res = bus.accum & bus.data;
            3'd4:    res = bus.accum | bus.data;
            3'd5:    res = bus.accum ^ bus.data;
            3'd6:    res = bus.data;
            default: res = bus.accum;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = is_mul ? BUSY : DONE;
            BUSY: if (mul_last) state_nx = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    if (accept) state_nx = is_mul ? BUSY : DONE;
                    else        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) state <= IDLE;
        else       state <= state_nx;
    end

    // A MUL accepted from DONE leaves out_r untouched until the product lands.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            out_r   <= '0;
            carry_r <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            cnt     <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= {{WIDTH{1'b0}}, bus.accum};
                mplier <= bus.data;
                prod   <= '0;
                cnt    <= '0;
            end else begin
                out_r   <= res;
                carry_r <= res_c;
            end
        end else if (state == BUSY) begin
            prod   <= prod_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (mul_last) begin
                out_r   <= prod_nx[WIDTH-1:0];
                carry_r <= |prod_nx[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign bus.out       = out_r;
    assign bus.carry     = carry_r;
    assign bus.zero      = (out_r == '0);
    assign bus.neg       = out_r[WIDTH-1];
    assign bus.out_valid = (state == DONE);
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized and directed checks of alu_mc against a behavioural model
module tb_alu_mc;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();
    alu_mc_if #(.WIDTH(W)) bus2 ();

    alu_mc #(.WIDTH(W), .MUL_EN(1)) dut  (.clk(clk), .rst_(rst_), .bus(bus));
    alu_mc #(.WIDTH(W), .MUL_EN(0)) dut2 (.clk(clk), .rst_(rst_), .bus(bus2));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ia, ib, m;
        logic [W-1:0] r;
        logic c;
        ia = a; ib = b; m = 1 << W; c = 1'b0;
        case (op)
            3'd0: r = a;
            3'd1: begin r = W'((ia + ib) % m); c = (ia + ib) >= m; end
            3'd2: begin r = W'((ia + m - ib) % m); c = ia < ib; end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = b;
            default: begin r = W'((ia * ib) % m); c = (ia * ib) >= m; end
        endcase
        return {c, r};
    endfunction

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        int           ready;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] last_res = '0;
    logic         last_c = 1'b0;
    int           cyc = 0;
    bit           mon_en = 1'b0;

    // Model: one outstanding result, visible from its ready cycle until taken.
    always @(posedge clk) begin
        bit   v, ir;
        logic [W:0] m;
        exp_t e;
        if (!rst_) begin
            q.delete();
            last_res = '0;
            last_c = 1'b0;
            mon_en = 1'b1;
        end else begin
            v  = (q.size() > 0) && (cyc >= q[0].ready);
            ir = (q.size() == 0) || (v && bus.out_ready);
            if (v && bus.out_ready) begin
                last_res = q[0].res;
                last_c = q[0].c;
                void'(q.pop_front());
            end
            if (bus.in_valid && ir) begin
                m = model(bus.opcode, bus.accum, bus.data);
                e.res = m[W-1:0];
                e.c = m[W];
                e.ready = cyc + 1 + ((bus.opcode == 3'd7) ? W : 0);
                q.push_back(e);
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        bit v, ir;
        logic [W-1:0] er;
        logic ec;
        if (mon_en) begin
            v  = (q.size() > 0) && (cyc >= q[0].ready);
            er = v ? q[0].res : last_res;
            ec = v ? q[0].c : last_c;
            ir = rst_ && ((q.size() == 0) || (v && bus.out_ready));
            chk("sb_out_valid", bus.out_valid, v);
            chk("sb_in_ready", bus.in_ready, ir);
            chk("sb_out", bus.out, er);
            chk("sb_carry", bus.carry, ec);
            chk("sb_zero", bus.zero, er == '0);
            chk("sb_neg", bus.neg, er[W-1]);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.opcode = op;
        bus.accum = a;
        bus.data = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
                return;
            end
        end
        chk("issue_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $finish;
    end

    initial begin
        bus.in_valid = 1'b0; bus.opcode = '0; bus.accum = '0; bus.data = '0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.opcode = '0; bus2.accum = '0; bus2.data = '0; bus2.out_ready = 1'b1;

        chk("model_add", model(3'd1, 8'hF0, 8'h20), 9'h110);
        chk("model_sub", model(3'd2, 8'h05, 8'h06), 9'h1FF);
        chk("model_mul", model(3'd7, 8'h0C, 8'h0B), 9'h084);
        chk("model_mul_ovf", model(3'd7, 8'h10, 8'h10), 9'h100);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1 rst_ = 1'b1;
        @(negedge clk);
        chk("rst_out", bus.out, 8'h00);
        chk("rst_zero", bus.zero, 1'b1);
        chk("rst_carry", bus.carry, 1'b0);
        chk("rst_neg", bus.neg, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready_rel", bus.in_ready, 1'b1);

        issue(3'd1, 8'hF0, 8'h20);
        @(negedge clk);
        chk("add_out", bus.out, 8'h10);
        chk("add_carry", bus.carry, 1'b1);
        chk("add_zero", bus.zero, 1'b0);
        chk("add_neg", bus.neg, 1'b0);
        chk("add_valid", bus.out_valid, 1'b1);

        issue(3'd2, 8'h05, 8'h06);
        @(negedge clk);
        chk("sub_out", bus.out, 8'hFF);
        chk("sub_carry", bus.carry, 1'b1);
        chk("sub_neg", bus.neg, 1'b1);

        issue(3'd7, 8'h0C, 8'h0B);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("mul_busy_in_ready", bus.in_ready, 1'b0);
            chk("mul_busy_valid", bus.out_valid, 1'b0);
        end
        @(negedge clk);
        chk("mul_out", bus.out, 8'h84);
        chk("mul_carry", bus.carry, 1'b0);
        chk("mul_valid", bus.out_valid, 1'b1);

        issue(3'd7, 8'h10, 8'h10);
        repeat (W + 1) @(negedge clk);
        chk("mul2_out", bus.out, 8'h00);
        chk("mul2_zero", bus.zero, 1'b1);
        chk("mul2_carry", bus.carry, 1'b1);

        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        issue(3'd5, 8'hAA, 8'hAA);
        bus.in_valid = 1'b1; bus.opcode = 3'd1; bus.accum = 8'h01; bus.data = 8'h02;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out", bus.out, 8'h00);
            chk("bp_zero", bus.zero, 1'b1);
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_in_ready", bus.in_ready, 1'b0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_new_out", bus.out, 8'h03);
        chk("bp_new_valid", bus.out_valid, 1'b1);

        @(posedge clk);
        #1 bus.in_valid = 1'b1; bus.opcode = 3'd3; bus.accum = 8'hF0; bus.data = 8'h3C;
        @(posedge clk);
        #1 bus.opcode = 3'd4;
        @(negedge clk);
        chk("b2b_and", bus.out, 8'h30);
        chk("b2b_and_valid", bus.out_valid, 1'b1);
        @(posedge clk);
        #1 bus.opcode = 3'd6;
        @(negedge clk);
        chk("b2b_or", bus.out, 8'hFC);
        chk("b2b_or_valid", bus.out_valid, 1'b1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_passb", bus.out, 8'h3C);
        chk("b2b_passb_valid", bus.out_valid, 1'b1);

        issue(3'd7, 8'h07, 8'h09);
        repeat (3) @(posedge clk);
        #1 rst_ = 1'b0;
        @(posedge clk);
        #1 rst_ = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_valid", bus.out_valid, 1'b0);
            chk("abort_out", bus.out, 8'h00);
        end

        @(posedge clk);
        #1 bus2.in_valid = 1'b1; bus2.opcode = 3'd7; bus2.accum = 8'h5A; bus2.data = 8'h03;
        @(posedge clk);
        #1 bus2.in_valid = 1'b0;
        @(negedge clk);
        chk("nomul_out", bus2.out, 8'h5A);
        chk("nomul_valid", bus2.out_valid, 1'b1);
        chk("nomul_carry", bus2.carry, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.opcode    = 3'($urandom_range(0, 7));
            bus.accum     = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
            bus.data      = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (W + 4) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 SHALL have parameter MUL_EN, default 1; 1 enables multi-cycle multiply, 0 makes opcode 7 behave as PASSA.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 opcode  input  3  operation select (see REQ-012).
REQ-008 accum  input  WIDTH  operand A.
REQ-009 data  input  WIDTH  operand B.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-011a out  output  WIDTH  result, registered.
REQ-011b zero, carry, neg  output  1 each  result flags, registered alongside out.

Function
REQ-012 Opcodes SHALL be: 0 PASSA (A), 1 ADD (A+B), 2 SUB (A-B), 3 AND, 4 OR, 5 XOR, 6 PASSB (B), 7 MUL (low WIDTH bits of A*B).
REQ-013 Request SHALL be accepted on a rising edge where in_valid && in_ready; operands and opcode are captured at that edge and later input changes are ignored.
REQ-014 FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-015 IDLE: accept with opcode 0-6 (or 7 with MUL_EN=0) -> DONE, result registered at that edge; accept with opcode 7 and MUL_EN=1 -> BUSY.
REQ-016 BUSY: shift-add multiplier, one multiplier bit per cycle; after exactly WIDTH cycles in BUSY -> DONE with result registered.
REQ-017 DONE: out_valid=1; out/flags held stable until out_valid && out_ready.
REQ-018 DONE with out_ready=1: result retires; if in_valid also high, the new request is accepted in the same edge (next state per REQ-015 rules); otherwise -> IDLE.
REQ-019 in_ready SHALL be 1 in IDLE, 0 in BUSY, equal to out_ready in DONE (combinational).
REQ-020 Latency: single-cycle ops out_valid on the cycle after acceptance; MUL out_valid WIDTH+1 cycles after acceptance; sustained throughput one single-cycle op per clock when out_ready=1.
REQ-021 ADD: carry = carry-out of WIDTH-bit add; SUB: carry = borrow (1 when A<B unsigned); MUL: carry = 1 if bits [2*WIDTH-1:WIDTH] of full product nonzero; all others carry=0.
REQ-022 zero = (out==0); neg = out[WIDTH-1]; both computed from the registered result.
REQ-023 Arithmetic SHALL be unsigned, wrap modulo 2^WIDTH.
REQ-024 out_valid SHALL be 0 in IDLE and BUSY; out/flags keep last retired value when out_valid=0.

Reset
REQ-025 rst_=0 at a rising edge SHALL force IDLE, out=0, zero=1, carry=0, neg=0, out_valid=0, multiplier counter/accumulator cleared.
REQ-026 Reset asserted during BUSY or DONE SHALL abort the operation; no result is produced and no stale out_valid appears after release.
REQ-027 in_ready SHALL be 0 while rst_=0; first acceptance possible on the first edge with rst_=1.

Verification (WIDTH=8, MUL_EN=1 unless stated)
REQ-028 Reset -> out=0x00, zero=1, carry=0, neg=0, out_valid=0, in_ready=1 after release.
REQ-029 ADD A=0xF0 B=0x20, out_ready=1 -> next cycle out=0x10, carry=1, zero=0, neg=0; SUB A=0x05 B=0x06 -> out=0xFF, carry=1, neg=1.
REQ-030 MUL A=0x0C B=0x0B -> in_ready=0 for 8 cycles, out=0x84, carry=0 on cycle 9; MUL A=0x10 B=0x10 -> out=0x00, zero=1, carry=1.
REQ-031 Backpressure: XOR A=0xAA B=0xAA with out_ready=0 for 5 cycles -> out=0x00, zero=1 held, in_ready=0; new in_valid ignored until out_ready=1, then accepted same edge.
REQ-032 Back-to-back: AND, OR, PASSB issued on consecutive cycles with out_ready=1 -> three results on three consecutive cycles, in order.
REQ-033 Reset mid-MUL (cycle 4 of BUSY) -> IDLE, out_valid never asserts for aborted op; MUL_EN=0 with opcode 7 -> out=A after one cycle.
